dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Target-side data-memory block answering the CPU core's load/store requests over a valid/ready
//   request/response handshake. Accepts one request at a time and inserts WAIT_CYCLES wait states.
//   Performs byte/half/word stores with lane enables, and returns loads right-justified, zero-padded.
//   Flags misaligned and out-of-range accesses. Replaces the zero-latency data memory for multicycle/pipelined cores.
// PARAMETERS
//   ADDR_WIDTH   10  word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  2   wait states between accept and response (0..15)
// PORTS
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   block can accept a request (high only in IDLE)
//   req_we       in   1   1 = store, 0 = load
//   req_size     in   2   00 = word, 01 = half, 10 = byte, 11 = reserved (treated as error)
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data; byte uses [7:0], half uses [15:0]
//   resp_valid   out  1   response present
//   resp_ready   in   1   core accepts response
//   resp_rdata   out  32  load data, right-justified, upper bits zero; 0 for stores and errors
//   resp_err     out  1   misaligned, out-of-range or reserved-size access
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
//     Captured request registers are cleared. Memory array is NOT cleared.
//     req_ready=1 from the first edge after release.
//   - FSM IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: req_ready=1. On req_valid&req_ready, latch we/size/addr/wdata and compute err.
//       If err, or WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
//     WAIT: counter decrements each cycle. When counter==0, go to RESP.
//     RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1, then go to IDLE.
//   - Latency: accept at edge T -> resp_valid high after edge T+1+WAIT_CYCLES.
//     An error response is high after edge T+1. The earliest next accept is the cycle after the response handshake.
//   - Error: half with addr[0]=1; word with addr[1:0]!=0; size 11; or addr[31:ADDR_WIDTH+2]!=0.
//     An error suppresses the write and forces resp_rdata=0.
//   - Store is committed on the edge that enters RESP, never earlier. Little-endian lanes:
//     byte enable = 1<<addr[1:0]; half enable = 0011 or 1100 by addr[1]; word enable = 1111.
//     Byte data is replicated to all lanes, half data to both halves, before masking.
//   - Load reads the word at addr[ADDR_WIDTH+1:2] on the edge entering RESP.
//     Shift right by 8*addr[1:0] (byte) or 16*addr[1] (half), then mask to size.
//     Sign extension is done by the core.
//   - req_valid in WAIT or RESP is ignored (req_ready=0). Request inputs need not stay stable after accept.
//   - Reset mid-transaction aborts it: a store not yet committed is lost and no response is issued.
// STRUCTURE
//   - Shared define file mem_bus_def.v: size codes MEM_SZ_W/H/B, state codes S_IDLE/S_WAIT/S_RESP.
//     The core's load/store control uses the same file.
//   - One combinational sub-module mem_lane_align: (size, addr[1:0], wdata, rword) -> (be[3:0], wword, rdata, misalign).
//   - Top holds the FSM, wait counter, captured request registers, and the memory array with per-byte write enable.
// TESTING (WAIT_CYCLES=2 unless noted; T = accept edge)
//   1. Word store/load: sw 0xDEADBEEF @0x10 -> resp_valid after T+3, err=0, rdata=0.
//      Then lw @0x10 -> rdata=0xDEADBEEF.
//   2. Byte lanes: sb 0xAA @0x11 -> lw @0x10 = 0xDEADAAEF; lb @0x13 -> rdata=0x000000DE.
//   3. Half lanes: sh 0x1234 @0x12 -> lw @0x10 = 0x1234AAEF; lh @0x12 -> rdata=0x00001234.
//   4. Errors: lw @0x12, sh @0x11 and lw @(1<<(ADDR_WIDTH+2)) each -> err=1 and rdata=0 after T+1.
//      Memory is unchanged.
//   5. Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, rdata and err are stable and req_ready=0.
//      A request pulsed meanwhile is not accepted.
//   6. Reset during WAIT of sw 0x55 @0x20 -> after release resp_valid=0 and req_ready=1; lw @0x20 returns the old value.
//      WAIT_CYCLES=0 build: lw returns after T+1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: size codes and FSM states shared with the core's load/store control
package dmem_responder_pkg;
    typedef enum logic [1:0] {
        MEM_SZ_W = 2'b00,
        MEM_SZ_H = 2'b01,
        MEM_SZ_B = 2'b10,
        MEM_SZ_R = 2'b11
    } mem_size_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_if: valid/ready request/response bus between core (master) and data memory (slave)
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder_align.sv
// mem_lane_align: little-endian lane enables, store replication, load extraction and alignment check
module mem_lane_align
    import dmem_responder_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic [31:0] shifted;
    always_comb begin
        be = size == MEM_SZ_W ? 4'b1111 :
             size == MEM_SZ_H ? (offset[1] ? 4'b1100 : 4'b0011) :
             size == MEM_SZ_B ? 4'b0001 << offset : 4'b0000;
        wword = size == MEM_SZ_B ? {4{wdata[7:0]}} :
                size == MEM_SZ_H ? {2{wdata[15:0]}} : wdata;
        shifted = size == MEM_SZ_B ? rword >> {offset, 3'b000} :
                  size == MEM_SZ_H ? rword >> {offset[1], 4'b0000} : rword;
        rdata = size == MEM_SZ_B ? {24'b0, shifted[7:0]} :
                size == MEM_SZ_H ? {16'b0, shifted[15:0]} : shifted;
        misalign = size == MEM_SZ_R || (size == MEM_SZ_H && offset[0]) ||
                   (size == MEM_SZ_W && offset != 2'b00);
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with programmable wait states and error flagging
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    state_t          state, next_state;
    logic [3:0]      cnt;
    logic            cap_we;
    mem_size_t       cap_size;
    logic [31:0]     cap_addr, cap_wdata;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [0:2**ADDR_WIDTH-1];

    logic            accept, enter_resp, err, misalign;
    logic            cur_we;
    mem_size_t       cur_size;
    logic [31:0]     cur_addr, cur_wdata, rdata, wword;
    logic [3:0]      be;
    logic [ADDR_WIDTH-1:0] idx;

    // In IDLE the live inputs drive the datapath so a zero-wait access can complete on its accept edge
    assign cur_we    = state == S_IDLE ? bus.req_we : cap_we;
    assign cur_size  = state == S_IDLE ? mem_size_t'(bus.req_size) : cap_size;
    assign cur_addr  = state == S_IDLE ? bus.req_addr : cap_addr;
    assign cur_wdata = state == S_IDLE ? bus.req_wdata : cap_wdata;
    assign idx       = cur_addr[ADDR_WIDTH+1:2];
    assign err       = misalign || (cur_addr >> (ADDR_WIDTH + 2)) != 32'd0;

    assign bus.req_ready  = state == S_IDLE && rst;
    assign bus.resp_valid = state == S_RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign accept         = bus.req_valid && bus.req_ready;
    assign enter_resp     = rst && ((accept && (err || WAIT_CYCLES == 0)) ||
                                    (state == S_WAIT && cnt == 4'd0));

    mem_lane_align u_align (
        .size     (cur_size),
        .offset   (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wword    (wword),
        .rdata    (rdata),
        .misalign (misalign)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (accept) next_state = (err || WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
            S_RESP:  if (bus.resp_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_size  <= MEM_SZ_W;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_we    <= bus.req_we;
                cap_size  <= mem_size_t'(bus.req_size);
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                cnt       <= WAIT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= (err || cur_we) ? 32'd0 : rdata;
                err_q   <= err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven checks of dmem_responder plus backpressure, reset-abort and zero-wait sequences
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic v_valid = 1'b0, v_we = 1'b0, v_resp_ready = 1'b0;
    logic [1:0]  v_size = 2'b00;
    logic [31:0] v_addr = 32'd0, v_wdata = 32'd0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_if bus_a ();
    dmem_if bus_b ();

    assign bus_a.req_valid  = v_valid & ~sel;
    assign bus_b.req_valid  = v_valid & sel;
    assign bus_a.resp_ready = v_resp_ready & ~sel;
    assign bus_b.resp_ready = v_resp_ready & sel;
    assign bus_a.req_we = v_we;     assign bus_b.req_we = v_we;
    assign bus_a.req_size = v_size; assign bus_b.req_size = v_size;
    assign bus_a.req_addr = v_addr; assign bus_b.req_addr = v_addr;
    assign bus_a.req_wdata = v_wdata; assign bus_b.req_wdata = v_wdata;

    wire        req_ready  = sel ? bus_b.req_ready  : bus_a.req_ready;
    wire        resp_valid = sel ? bus_b.resp_valid : bus_a.resp_valid;
    wire [31:0] resp_rdata = sel ? bus_b.resp_rdata : bus_a.resp_rdata;
    wire        resp_err   = sel ? bus_b.resp_err   : bus_a.resp_err;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(bus_a));
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        v_we = we; v_size = size; v_addr = addr; v_wdata = wdata; v_valid = 1'b1;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        v_we = 1'($urandom); v_size = 2'($urandom); v_addr = $urandom; v_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        v_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        v_resp_ready = 1'b0;
        check("valid_drop", {31'd0, resp_valid}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int lat;
        tbl[0]  = '{1'b1, 2'b00, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 3};
        tbl[1]  = '{1'b1, 2'b00, 32'h20,   32'h11223344, 32'h0,        1'b0, 3};
        tbl[2]  = '{1'b0, 2'b00, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3};
        tbl[3]  = '{1'b1, 2'b10, 32'h11,   32'h123456AA, 32'h0,        1'b0, 3};
        tbl[4]  = '{1'b0, 2'b00, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0, 3};
        tbl[5]  = '{1'b0, 2'b10, 32'h13,   32'h0,        32'h000000DE, 1'b0, 3};
        tbl[6]  = '{1'b1, 2'b01, 32'h12,   32'hABCD1234, 32'h0,        1'b0, 3};
        tbl[7]  = '{1'b0, 2'b00, 32'h10,   32'h0,        32'h1234AAEF, 1'b0, 3};
        tbl[8]  = '{1'b0, 2'b01, 32'h12,   32'h0,        32'h00001234, 1'b0, 3};
        tbl[9]  = '{1'b0, 2'b00, 32'h12,   32'h0,        32'h0,        1'b1, 1};
        tbl[10] = '{1'b1, 2'b01, 32'h11,   32'hFFFFFFFF, 32'h0,        1'b1, 1};
        tbl[11] = '{1'b0, 2'b00, 32'h1000, 32'h0,        32'h0,        1'b1, 1};
        tbl[12] = '{1'b1, 2'b00, 32'h1010, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
        tbl[13] = '{1'b0, 2'b11, 32'h10,   32'h0,        32'h0,        1'b1, 1};
        tbl[14] = '{1'b0, 2'b00, 32'h10,   32'h0,        32'h1234AAEF, 1'b0, 3};
        tbl[15] = '{1'b0, 2'b10, 32'h10,   32'h0,        32'h000000EF, 1'b0, 3};
        tbl[16] = '{1'b0, 2'b01, 32'h10,   32'h0,        32'h0000AAEF, 1'b0, 3};
        tbl[17] = '{1'b0, 2'b10, 32'h12,   32'h0,        32'h00000034, 1'b0, 3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("post_rst_rdata", resp_rdata, 32'd0);
        check("post_rst_err", {31'd0, resp_err}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            issue(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, lat);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            check($sformatf("vec%0d_rdata", i), resp_rdata, tbl[i].rdata);
            check($sformatf("vec%0d_err", i), {31'd0, resp_err}, {31'd0, tbl[i].err});
            finish_resp();
        end

        // Backpressure: response held, a stray store pulsed meanwhile must be ignored
        issue(1'b0, 2'b00, 32'h10, 32'h0, lat);
        check("bp_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_rdata", resp_rdata, 32'h1234AAEF);
            check("bp_err", {31'd0, resp_err}, 32'd0);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            v_valid = (i == 2); v_we = 1'b1; v_size = 2'b00; v_addr = 32'h10; v_wdata = 32'h0;
            @(posedge clk);
            #1;
            v_valid = 1'b0;
        end
        finish_resp();
        issue(1'b0, 2'b00, 32'h10, 32'h0, lat);
        check("bp_mem_kept", resp_rdata, 32'h1234AAEF);
        finish_resp();

        // Reset while a store waits: the store is dropped and no response appears
        @(negedge clk);
        v_we = 1'b1; v_size = 2'b00; v_addr = 32'h20; v_wdata = 32'h55; v_valid = 1'b1;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        rst = 1'b0;
        #2;
        check("abort_valid_in_rst", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 2'b00, 32'h20, 32'h0, lat);
        check("abort_old_value", resp_rdata, 32'h11223344);
        finish_resp();

        // Zero-wait build
        sel = 1'b1;
        issue(1'b1, 2'b00, 32'h40, 32'hCAFEF00D, lat);
        check("w0_store_lat", lat, 1);
        finish_resp();
        issue(1'b0, 2'b00, 32'h40, 32'h0, lat);
        check("w0_load_lat", lat, 1);
        check("w0_load_rdata", resp_rdata, 32'hCAFEF00D);
        finish_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
